// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - counts rising edges of sig_in over a GATE-cycle window and reports a frequency code
module freq_meter #(
   parameter int GATE    = 1250,
   parameter int W       = 7,
   parameter int TIMEOUT = 2500
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         sig_in,
   output logic [W-1:0] code,
   output logic         valid,
   output logic         ovf,
   output logic         nosig,
   output logic         busy
);
   localparam int GW = (GATE > 1) ? $clog2(GATE) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [GW-1:0] GATE_LAST = GW'(GATE - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE} state_t;

   state_t        state_q;
   logic          s1_q, s2_q, s3_q;
   logic [TW-1:0] to_cnt_q;
   logic [GW-1:0] gate_cnt_q;
   logic [W-1:0]  edge_cnt_q, edge_cnt_d;
   logic          sat_q, sat_d;
   logic [W-1:0]  code_q;
   logic          valid_q, ovf_q, nosig_q, busy_q;
   logic          sig_edge;

   assign sig_edge = s2_q & ~s3_q;

   // Saturating count including this cycle's edge, so the last window cycle still counts.
   always_comb begin
      edge_cnt_d = edge_cnt_q;
      sat_d      = sat_q;
      if (sig_edge) begin
         if (edge_cnt_q == CNT_MAX) sat_d = 1'b1;
         else                       edge_cnt_d = edge_cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         s3_q       <= 1'b0;
         to_cnt_q   <= '0;
         gate_cnt_q <= '0;
         edge_cnt_q <= '0;
         sat_q      <= 1'b0;
         code_q     <= '0;
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
         nosig_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         s1_q    <= sig_in;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (en) begin
                  state_q  <= S_ARM;
                  busy_q   <= 1'b1;
                  to_cnt_q <= '0;
               end
            end
            S_ARM: begin
               if (!en) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else if (sig_edge) begin
                  state_q    <= S_GATE;
                  gate_cnt_q <= '0;
                  edge_cnt_q <= '0;
                  sat_q      <= 1'b0;
               end else if (to_cnt_q == TO_LAST) begin
                  code_q   <= '0;
                  ovf_q    <= 1'b0;
                  nosig_q  <= 1'b1;
                  valid_q  <= 1'b1;
                  to_cnt_q <= '0;
               end else begin
                  to_cnt_q <= to_cnt_q + TW'(1);
               end
            end
            S_GATE: begin
               if (!en) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  gate_cnt_q <= gate_cnt_q + GW'(1);
                  edge_cnt_q <= edge_cnt_d;
                  sat_q      <= sat_d;
                  if (gate_cnt_q == GATE_LAST) begin
                     code_q   <= edge_cnt_d;
                     ovf_q    <= sat_d;
                     nosig_q  <= 1'b0;
                     valid_q  <= 1'b1;
                     state_q  <= S_ARM;
                     to_cnt_q <= '0;
                     sat_q    <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign code  = code_q;
   assign valid = valid_q;
   assign ovf   = ovf_q;
   assign nosig = nosig_q;
   assign busy  = busy_q;
endmodule
